// File: rtl/countdown_display_if.sv
// countdown_display_if: groups the countdown inputs and the display/buzzer
// outputs of countdown_display. The master side (the counter plus whatever
// observes the display) drives TimeH/TimeL/beep/mute. The slave side
// (countdown_display) drives seg_n/dig_n/buzzer.
interface countdown_display_if;
    logic [3:0] TimeH;
    logic [3:0] TimeL;
    logic       beep;
    logic       mute;
    logic [6:0] seg_n;
    logic [1:0] dig_n;
    logic       buzzer;

    modport master (
        output TimeH, TimeL, beep, mute,
        input  seg_n, dig_n, buzzer
    );

    modport slave (
        input  TimeH, TimeL, beep, mute,
        output seg_n, dig_n, buzzer
    );
endinterface

// File: rtl/countdown_display.sv
// countdown_display: two-digit multiplexed seven-segment driver and buzzer for
// a BCD countdown. The BCD inputs come from a slow clock domain. They are
// synchronised, and skewed updates are rejected, before they reach the display.
// The display blanks a leading tens zero. At zero the unit blinks "00" and
// sounds the buzzer until the alarm ends. A sticky mute silences the buzzer
// for the current alarm only.
// Optional feature macro: BUZZER_TONE_EN. When it is defined, the buzzer
// produces a square-wave tone. When it is not defined, the buzzer is a
// steady level.
module countdown_display #(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 12500000,
    parameter int unsigned TONE_DIV  = 12500
) (
    input  logic                 clock,
    input  logic                 reset,
    countdown_display_if.slave   bus
);

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    // Held value at reset is {beep=0, TimeH=1, TimeL=5}.
    localparam logic [8:0]  HELD_RST = {1'b0, 4'd1, 4'd5};

    typedef enum logic {SCAN_L, SCAN_H} scan_state_t;

    scan_state_t        state, state_next;
    logic [SCAN_W-1:0]  pres, pres_next;
    logic [8:0]         s1, s2, s3, held, held_next;
    logic               alarm, alarm_next;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic               muted, muted_next;
    logic [6:0]         seg_d;
    logic [1:0]         dig_d;
    logic               buz_d;

    function automatic logic [6:0] seg_code(input logic [3:0] v);
        case (v)
            4'd0:    seg_code = 7'h40;
            4'd1:    seg_code = 7'h79;
            4'd2:    seg_code = 7'h24;
            4'd3:    seg_code = 7'h30;
            4'd4:    seg_code = 7'h19;
            4'd5:    seg_code = 7'h12;
            4'd6:    seg_code = 7'h02;
            4'd7:    seg_code = 7'h78;
            4'd8:    seg_code = 7'h00;
            4'd9:    seg_code = 7'h10;
            default: seg_code = 7'h3F;
        endcase
    endfunction

    // Three-stage synchroniser for the counter outputs, followed by the held register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1   <= HELD_RST;
            s2   <= HELD_RST;
            s3   <= HELD_RST;
            held <= HELD_RST;
        end else begin
            s1   <= {bus.beep, bus.TimeH, bus.TimeL};
            s2   <= s1;
            s3   <= s2;
            held <= held_next;
        end
    end

    // Load only when two consecutive stages agree, so multi-bit skew never lands in held.
    always_comb begin
        held_next = held;
        if (s2 == s3) held_next = s2;
    end

    assign alarm      = held[8];
    assign alarm_next = held_next[8];

    // Scan state register and prescaler.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SCAN_L;
            pres  <= '0;
        end else begin
            state <= state_next;
            pres  <= pres_next;
        end
    end

    // Prescaler wrap toggles the scanned digit.
    always_comb begin
        state_next = state;
        pres_next  = pres + 1'b1;
        if (pres == SCAN_W'(SCAN_DIV - 1)) begin
            pres_next  = '0;
            state_next = (state == SCAN_L) ? SCAN_H : SCAN_L;
        end
    end

    // Blink timer. It is keyed on the next alarm value so that it clears on the same edge as the alarm.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (!alarm_next) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Sticky mute, armed only during an alarm and dropped when the alarm ends.
    always_comb begin
        muted_next = muted;
        if (!alarm_next)
            muted_next = 1'b0;
        else if (bus.mute && alarm)
            muted_next = 1'b1;
    end

    // Mute flag register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) muted <= 1'b0;
        else        muted <= muted_next;
    end

`ifdef BUZZER_TONE_EN
    localparam int unsigned TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;

    logic [TONE_W-1:0] tone_cnt;
    logic              tone;
    logic              sounding_next;

    assign sounding_next = alarm_next & ~muted_next;

    // Tone generator. It is held at zero whenever the buzzer is not about to sound.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (!sounding_next) begin
            tone_cnt <= '0;
            tone     <= 1'b0;
        end else if (tone_cnt == TONE_W'(TONE_DIV - 1)) begin
            tone_cnt <= '0;
            tone     <= ~tone;
        end else begin
            tone_cnt <= tone_cnt + 1'b1;
        end
    end

    assign buz_d = alarm & ~muted & tone;
`else
    logic unused_tone_div;
    assign unused_tone_div = ^TONE_DIV;
    assign buz_d = alarm & ~muted;
`endif

    // Next output values. They use the upcoming scan slot, so registering them lines up with the scan state.
    always_comb begin
        seg_d = seg_code((state_next == SCAN_H) ? held[7:4] : held[3:0]);
        if (state_next == SCAN_H && held[7:4] == 4'd0 && !alarm)
            seg_d = '1;
        if (pres_next == '0)
            dig_d = '1;
        else if (alarm && blink_phase)
            dig_d = '1;
        else
            dig_d = (state_next == SCAN_L) ? 2'b10 : 2'b01;
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bus.seg_n  <= '1;
            bus.dig_n  <= '1;
            bus.buzzer <= 1'b0;
        end else begin
            bus.seg_n  <= seg_d;
            bus.dig_n  <= dig_d;
            bus.buzzer <= buz_d;
        end
    end

endmodule

// File: tb/tb_countdown_display.sv
// tb_countdown_display: directed test for countdown_display with
// SCAN_DIV=4, BLINK_DIV=16 and TONE_DIV=3. The expected outputs for each
// clock edge are built from an edge counter and the current phase
// settings, pushed to a scoreboard queue, then popped and compared after the edge.
// Follows BUZZER_TONE_EN for the expected buzzer behaviour.
module tb_countdown_display;

    typedef struct {
        string      tag;
        logic [6:0] seg;
        logic [1:0] dig;
        logic       buz;
    } exp_t;

`ifdef BUZZER_TONE_EN
    localparam bit TONE = 1'b1;
`else
    localparam bit TONE = 1'b0;
`endif

    logic clock;
    logic reset;
    countdown_display_if bus_if();

    countdown_display #(
        .SCAN_DIV  (4),
        .BLINK_DIV (16),
        .TONE_DIV  (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    exp_t       q[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         e           = 0;
    int         dark_base   = -1;
    int         buz_base    = -1;
    logic [6:0] seg_l;
    logic [6:0] seg_h;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input exp_t x);
        vectors++;
        assert (bus_if.seg_n === x.seg) else begin
            miscompares++;
            $error("FAIL %s edge %0d seg_n: got %h want %h", x.tag, e, bus_if.seg_n, x.seg);
        end
        vectors++;
        assert (bus_if.dig_n === x.dig) else begin
            miscompares++;
            $error("FAIL %s edge %0d dig_n: got %b want %b", x.tag, e, bus_if.dig_n, x.dig);
        end
        vectors++;
        assert (bus_if.buzzer === x.buz) else begin
            miscompares++;
            $error("FAIL %s edge %0d buzzer: got %b want %b", x.tag, e, bus_if.buzzer, x.buz);
        end
    endtask

    task automatic step(input string tag);
        exp_t x;
        bit   hi;
        e++;
        hi = ((e / 4) % 2) == 1;
        x.tag = tag;
        x.seg = hi ? seg_h : seg_l;
        if (e % 4 == 0)
            x.dig = 2'b11;
        else if (dark_base >= 0 && e >= dark_base && ((e - dark_base) / 16) % 2 == 1)
            x.dig = 2'b11;
        else
            x.dig = hi ? 2'b01 : 2'b10;
        if (buz_base >= 0 && e > buz_base)
            x.buz = TONE ? (((e - buz_base) / 3) % 2 == 1) : 1'b1;
        else
            x.buz = 1'b0;
        q.push_back(x);
        @(posedge clock);
        #1;
        chk(q.pop_front());
    endtask

    initial begin
        exp_t r;
        reset        = 1'b0;
        bus_if.TimeH = 4'd1;
        bus_if.TimeL = 4'd5;
        bus_if.beep  = 1'b0;
        bus_if.mute  = 1'b0;
        #20;
        r.tag = "reset"; r.seg = 7'h7F; r.dig = 2'b11; r.buz = 1'b0;
        q.push_back(r);
        chk(q.pop_front());
        #2 reset = 1'b1;

        // Scan of the reset held value 15.
        seg_l = 7'h12; seg_h = 7'h79;
        repeat (8) step("scan15");

        // 07: the tens digit is blanked after the input latency.
        bus_if.TimeH = 4'd0; bus_if.TimeL = 4'd7;
        repeat (4) step("lat_old");
        seg_l = 7'h78; seg_h = 7'h7F;
        repeat (8) step("blank07");

        // Alarm at 00. It rises in held on edge 24.
        bus_if.TimeL = 4'd0; bus_if.beep = 1'b1;
        dark_base = 24; buz_base = 24;
        repeat (4) step("alarm_rise");
        seg_l = 7'h40; seg_h = 7'h40;
        repeat (36) step("alarm");

        // One-cycle mute pulse. The buzzer goes silent and the blink continues.
        bus_if.mute = 1'b1;
        step("mute_pulse");
        bus_if.mute = 1'b0;
        buz_base = -1;
        repeat (15) step("muted");

        // Drop beep. The alarm clears on edge 80.
        bus_if.beep = 1'b0;
        repeat (4) step("drop");
        dark_base = -1; seg_h = 7'h7F;
        repeat (4) step("idle00");

        // Raise beep again. The mute is gone, so the buzzer resumes.
        bus_if.beep = 1'b1;
        dark_base = 88; buz_base = 88;
        repeat (4) step("rerise");
        seg_h = 7'h40;
        repeat (8) step("realarm");

        // Units value 0xA shows a dash.
        bus_if.TimeL = 4'hA;
        repeat (4) step("lat_A");
        seg_l = 7'h3F;
        repeat (9) step("dash");

        // Skewed update A -> 2 -> 3. Only the final value 3 appears, on edge 115.
        bus_if.TimeL = 4'd2;
        step("skew1");
        bus_if.TimeL = 4'd3;
        repeat (4) step("skew2");
        seg_l = 7'h30;
        repeat (6) step("skew_done");

        // Asynchronous reset in the middle of an alarm.
        #2 reset = 1'b0;
        #1;
        r.tag = "reset_mid"; r.seg = 7'h7F; r.dig = 2'b11; r.buz = 1'b0;
        q.push_back(r);
        chk(q.pop_front());

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/countdown_display.md
# countdown_display

Drives a two-digit multiplexed seven-segment display and the buzzer from the BCD countdown value (tens digit, units digit, zero flag) that the timing counter produces on its slow clock. It runs on the fast system clock and synchronises and debounces the counter outputs. It scans both digits with leading-zero blanking, blinks "00" and sounds the buzzer when the count reaches zero, and provides a sticky mute.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot (including guard cycle); must be ≥2.
- BLINK_DIV, 12500000: clock cycles per blink half-period during alarm.
- TONE_DIV, 12500: clock cycles per buzzer tone half-period; used only when the tone feature is compiled in.
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- TimeH  input  4  BCD tens digit from counter; asynchronous to clock.
- TimeL  input  4  BCD units digit from counter; asynchronous to clock.
- beep  input  1  zero flag from counter; asynchronous to clock.
- mute  input  1  synchronous level; silences buzzer for current alarm.
- seg_n  output  7  active-low segments, bit0=a … bit6=g.
- dig_n  output  2  active-low digit select; bit0=units, bit1=tens.
- buzzer  output  1  active-high buzzer drive.

## Operation
- Input capture:
  - {beep,TimeH,TimeL} (9 bits) passes through stages s1→s2→s3.
  - The held register loads s2 only when s2==s3, which rejects multi-bit skew.
  - Held values at reset: TimeH=1, TimeL=5, beep=0.
- Alarm: alarm = held beep.
- Scan FSM:
  - States SCAN_L (units) and SCAN_H (tens); reset to SCAN_L.
  - Prescaler counts 0..SCAN_DIV-1 and wraps to 0.
  - On wrap, state toggles.
  - While the prescaler is 0, the digit is in its guard slot: dig_n=2'b11.
- Digit enable:
  - Outside the guard slot, SCAN_L drives dig_n=2'b10 and SCAN_H drives 2'b01.
  - Exception: during alarm with blink phase 1, dig_n=2'b11.
- Segment encoding (seg_n hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - Any value >9 shows "-"=3F.
- Leading-zero blanking: in SCAN_H, held TimeH==0 and no alarm gives seg_n=7F. During alarm the tens digit shows 0.
- Blink:
  - A counter runs only during alarm; phase toggles every BLINK_DIV cycles.
  - Counter and phase are forced to 0 whenever alarm=0.
  - The first dark half-period therefore begins BLINK_DIV cycles after alarm rises.
- Mute:
  - Sticky flag muted is set when mute=1 and alarm=1.
  - It is cleared whenever alarm=0; mute is ignored when not in alarm.
- Buzzer: 0 when alarm=0 or muted=1; otherwise as set by Configuration. Display blinking is unaffected by mute.

## Timing
- Reset values:
  - seg_n=7F, dig_n=2'b11, buzzer=0.
  - Scan FSM=SCAN_L; prescaler, blink and tone counters=0.
  - muted=0; s1/s2/s3 = reset held value.
- All outputs are registered.
- Input latency: a stable input change reaches held on the 4th rising edge; seg_n reflects it on the 5th if that digit is scanned.
- First edge after reset release gives dig_n=2'b10, seg_n=digit of held TimeL (12 for 5).
- Each digit is lit for SCAN_DIV-1 cycles, then 1 guard cycle.
- seg_n changes only on the guard cycle or when held changes.
- mute sampled at edge N sets muted; buzzer is 0 from edge N+1.
- beep falling:
  - Held alarm clears on the 4th edge.
  - Blink, tone and muted clear on that edge.
  - buzzer=0 from the next edge.
- Asynchronous reset mid-scan or mid-alarm immediately forces all reset values. There is no resumption of blink or mute state.

## Configuration
- BUZZER_TONE_EN defined:
  - While alarm and not muted, buzzer is a square wave that toggles every TONE_DIV cycles.
  - It starts at 0; the first high edge is TONE_DIV cycles after alarm rises.
  - The tone counter is held at 0 when not sounding.
- BUZZER_TONE_EN undefined:
  - buzzer = alarm & ~muted as a steady level.
  - No tone counter is present.

## Test plan
Bench parameters: SCAN_DIV=4, BLINK_DIV=16, TONE_DIV=3.
- Reset, inputs H=1 L=5 beep=0 → dig_n cycles 10,10,10,11,01,01,01,11. seg_n: 12 in units slot, 79 in tens slot.
- Set H=0 L=7 → after 5 edges, units slot shows 78 and tens slot shows 7F (blanked).
- Set H=0 L=0 beep=1 → both digits show 40. Digits dark (dig_n=11) for 16-cycle halves, alternating. With the macro, buzzer toggles every 3 cycles; without it, buzzer stays 1.
- During alarm pulse mute for 1 cycle → buzzer 0 next edge and stays 0 while beep=1, blink continues. Drop and re-raise beep → buzzer resumes.
- Set TimeL=A → units slot shows 3F.
- Skewed input (TimeL bits changing on consecutive cycles) → held updates once, to the final value only. Assert reset mid-alarm → seg_n=7F, dig_n=11, buzzer=0 immediately.
